mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the CPU's single-port RAM between two requesters: the CPU memory path (port 0) and an I/O DMA engine (port 1).
//  The CPU port covers the MAR/MDR read and write accesses of fetch, ld and st.
//  Sequences each access through issue, latency wait and completion, then returns read data to the owner with a one-cycle done pulse.
//  Sits between the control-unit-driven datapath and the memory.
// PARAMETERS
//  AW       9   RAM address width
//  DW       32  data width
//  RAM_LAT  1   RAM read latency in clocks (1..7); ram_rdata is valid RAM_LAT clocks after the issue cycle
// PORTS
//  Clock      in   1   rising-edge clock
//  Reset      in   1   asynchronous reset, active-high
//  c_req      in   1   CPU request; held until c_done
//  c_we       in   1   CPU write (1) / read (0)
//  c_addr     in   AW  CPU address
//  c_wdata    in   DW  CPU write data
//  c_done     out  1   one-cycle completion pulse to the CPU
//  d_req      in   1   DMA request; held until d_done
//  d_we       in   1   DMA write / read
//  d_addr     in   AW  DMA address
//  d_wdata    in   DW  DMA write data
//  d_done     out  1   one-cycle completion pulse to the DMA
//  rdata      out  DW  read data; valid only in the done cycle
//  busy       out  1   high whenever the state is not IDLE
//  owner      out  1   0 = CPU, 1 = DMA; owner of the current or last transaction
//  ram_addr   out  AW  RAM address
//  ram_wdata  out  DW  RAM write data
//  ram_we     out  1   RAM write strobe
//  ram_rdata  in   DW  RAM read data
// BEHAVIOUR
//  Reset values: all outputs 0, state IDLE, rr_last = 1 (so the CPU wins the first contention in RR mode).
//  FSM states: IDLE -> ISSUE -> {WAIT (read) | DONE (write)}; WAIT -> DONE; DONE -> IDLE.
//  IDLE: on a rising Clock edge with any req high, pick a winner.
//   - latch its we, addr and wdata internally;
//   - set owner;
//   - go to ISSUE.
//  ISSUE (1 cycle): drive ram_addr and ram_wdata from the latched values.
//   - ram_we = 1 for a write only;
//   - load the wait counter with RAM_LAT.
//  WAIT: decrement the counter. At zero, capture ram_rdata into rdata and go to DONE.
//   - total time in WAIT is exactly RAM_LAT cycles.
//  DONE (1 cycle): assert the done pulse of the owner only, then return to IDLE.
//   - rdata holds the read value (0 for a write);
//   - a new request is not accepted in DONE.
//  Latency from request sampled to done:
//   - read = 2 + RAM_LAT cycles;
//   - write = 2 cycles.
//  Back-to-back accesses: minimum 3 + RAM_LAT (read) or 3 (write) cycles per transaction, IDLE included.
//  Requesters change req/we/addr/wdata only after their done pulse.
//   - Latched copies make mid-transaction input changes harmless.
//   - A req dropped before done: the transaction still completes and done is still pulsed.
//  ram_addr and ram_wdata are 0 outside ISSUE, and ram_we is 0 outside ISSUE.
//  Reset asserted mid-transaction: return immediately to IDLE with all outputs 0.
//   - An in-flight write in ISSUE is cut off (ram_we drops asynchronously).
//   - No done pulse is produced.
//  Contention (both req high in IDLE): per CONFIGURATION.
//  Single requester: always granted in the next cycle, independent of the priority mode.
// CONFIGURATION
//  MEMARB_RR_EN defined: round-robin on contention.
//   - The requester not granted last wins; rr_last updates on every grant.
//   - Max wait for either requester is one transaction.
//  MEMARB_RR_EN undefined: fixed priority, CPU always wins on contention.
//   - The DMA can starve; this is accepted for the single-program CPU bring-up.
// STRUCTURE
//  Package cpu_mem_pkg holds:
//   - state encodings ST_IDLE/ST_ISSUE/ST_WAIT/ST_DONE (2-bit);
//   - requester IDs REQ_CPU = 0 and REQ_DMA = 1;
//   - the default AW/DW.
//  Sub-module arb_pick2: combinational winner selection.
//   - Inputs: c_req, d_req, rr_last.
//   - Output: winner id.
//   - Behaviour switches on MEMARB_RR_EN.
//  The FSM, the latches, the wait counter and the output registers stay in mem_port_arbiter.
// TESTING
//  1. Reset: all outputs 0. CPU read addr 0x010, RAM_LAT = 1, RAM[0x010] = 0x1234ABCD:
//     ram_addr = 0x010 in the issue cycle; c_done + rdata = 0x1234ABCD exactly 3 cycles after req is sampled.
//  2. DMA write addr 0x1FF, data 0xDEADBEEF: ram_we = 1 for exactly one cycle with correct addr/data;
//     d_done 2 cycles after req; a readback of 0x1FF returns 0xDEADBEEF.
//  3. c_req and d_req rise together, twice:
//     - fixed mode: CPU, CPU;
//     - with MEMARB_RR_EN: CPU then DMA;
//     owner and the done pulses match in both modes.
//  4. Reset pulsed during WAIT of a read: busy = 0 and no done pulse;
//     a following request completes normally.
//  5. RAM_LAT = 3 read, with c_addr changed in mid-WAIT: the original address is used, done arrives 5 cycles after req,
//     and the data is correct.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
//  Module  : cpu_mem_pkg
//  Purpose : Shared state encodings, requester IDs and default widths for
//            the CPU/DMA memory port arbiter.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_mem_pkg;

    localparam int DEF_AW = 9;
    localparam int DEF_DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
//  Module  : mem_port_arbiter_if
//  Purpose : Requester, status and RAM-side signals of the memory arbiter.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if
    import cpu_mem_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);
    logic          c_req;
    logic          c_we;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata;
    logic          c_done;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_done;
    logic [DW-1:0] rdata;
    logic          busy;
    logic          owner;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_we;
    logic [DW-1:0] ram_rdata;

    // Arbiter side
    modport slave (
        input  c_req, c_we, c_addr, c_wdata, d_req, d_we, d_addr, d_wdata, ram_rdata,
        output c_done, d_done, rdata, busy, owner, ram_addr, ram_wdata, ram_we
    );

    // Requesters plus RAM side
    modport master (
        output c_req, c_we, c_addr, c_wdata, d_req, d_we, d_addr, d_wdata, ram_rdata,
        input  c_done, d_done, rdata, busy, owner, ram_addr, ram_wdata, ram_we
    );

endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter_arb_pick2.sv
// ============================================================================
//  Module  : arb_pick2
//  Purpose : Combinational winner select between CPU and DMA requests.
//            MEMARB_RR_EN selects round-robin; otherwise CPU has priority.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module arb_pick2
    import cpu_mem_pkg::*;
(
    input  wire logic c_req,
    input  wire logic d_req,
    input  wire logic rr_last,
    output logic      winner
);

`ifdef MEMARB_RR_EN
    always_comb begin
        winner = REQ_CPU;
        if (c_req && d_req) begin
            winner = (rr_last == REQ_CPU) ? REQ_DMA : REQ_CPU;
        end else if (d_req) begin
            winner = REQ_DMA;
        end
    end
`else
    // Fixed priority has no use for the grant history
    wire w_unused_rr = rr_last;

    always_comb begin
        winner = REQ_CPU;
        if (!c_req && d_req) begin
            winner = REQ_DMA;
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
//  Module  : mem_port_arbiter
//  Purpose : Shares a single-port RAM between CPU and DMA requesters with an
//            issue/wait/done sequence. Macro MEMARB_RR_EN enables round-robin.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int RAM_LAT = 1
)(
    input  wire logic         Clock,
    input  wire logic         Reset,
    mem_port_arbiter_if.slave bus
);

    localparam logic [2:0] c_ram_lat = 3'(RAM_LAT);

    state_t        r_state;
    logic [2:0]    r_cnt;
    logic          r_we;
    logic          r_rr_last;

    logic          w_winner;
    logic          w_we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;

    arb_pick2 u_pick (
        .c_req   (bus.c_req),
        .d_req   (bus.d_req),
        .rr_last (r_rr_last),
        .winner  (w_winner)
    );

    assign w_we    = (w_winner == REQ_DMA) ? bus.d_we    : bus.c_we;
    assign w_addr  = (w_winner == REQ_DMA) ? bus.d_addr  : bus.c_addr;
    assign w_wdata = (w_winner == REQ_DMA) ? bus.d_wdata : bus.c_wdata;

    // The RAM address/data registers double as the latched request copy
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_we          <= 1'b0;
            r_rr_last     <= REQ_DMA;
            bus.c_done    <= 1'b0;
            bus.d_done    <= 1'b0;
            bus.rdata     <= '0;
            bus.busy      <= 1'b0;
            bus.owner     <= REQ_CPU;
            bus.ram_addr  <= '0;
            bus.ram_wdata <= '0;
            bus.ram_we    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.c_req || bus.d_req) begin
                        r_state       <= ST_ISSUE;
                        bus.busy      <= 1'b1;
                        bus.owner     <= w_winner;
                        r_rr_last     <= w_winner;
                        r_we          <= w_we;
                        bus.ram_addr  <= w_addr;
                        bus.ram_wdata <= w_wdata;
                        bus.ram_we    <= w_we;
                    end
                end
                ST_ISSUE: begin
                    bus.ram_addr  <= '0;
                    bus.ram_wdata <= '0;
                    bus.ram_we    <= 1'b0;
                    r_cnt         <= c_ram_lat;
                    if (r_we) begin
                        r_state   <= ST_DONE;
                        bus.rdata <= '0;
                        if (bus.owner == REQ_DMA) bus.d_done <= 1'b1;
                        else                      bus.c_done <= 1'b1;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - 3'd1;
                    // Last wait cycle: RAM output is valid now
                    if (r_cnt == 3'd1) begin
                        r_state   <= ST_DONE;
                        bus.rdata <= bus.ram_rdata;
                        if (bus.owner == REQ_DMA) bus.d_done <= 1'b1;
                        else                      bus.c_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state    <= ST_IDLE;
                    bus.c_done <= 1'b0;
                    bus.d_done <= 1'b0;
                    bus.rdata  <= '0;
                    bus.busy   <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
//  Module  : tb_mem_port_arbiter
//  Purpose : Directed self-checking bench for mem_port_arbiter (RAM_LAT 1 and 3).
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    logic clk   = 1'b0;
    logic Reset = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(9), .DW(32)) if1 ();
    mem_port_arbiter_if #(.AW(9), .DW(32)) if3 ();

    mem_port_arbiter #(.AW(9), .DW(32), .RAM_LAT(1)) u_dut1 (
        .Clock (clk),
        .Reset (Reset),
        .bus   (if1.slave)
    );

    mem_port_arbiter #(.AW(9), .DW(32), .RAM_LAT(3)) u_dut3 (
        .Clock (clk),
        .Reset (Reset),
        .bus   (if3.slave)
    );

    // RAM models: synchronous read, latency 1 and 3
    logic [31:0] mem1 [0:511];
    logic [31:0] mem3 [0:511];
    logic [31:0] rd1;
    logic [31:0] p0, p1, p2;

    always @(posedge clk) begin
        if (Reset) mem1[9'h010] <= 32'h1234ABCD;
        else if (if1.ram_we) mem1[if1.ram_addr] <= if1.ram_wdata;
        rd1 <= mem1[if1.ram_addr];
    end
    assign if1.ram_rdata = rd1;

    always @(posedge clk) begin
        if (Reset) begin
            mem3[9'h044] <= 32'hA5A55A5A;
            mem3[9'h055] <= 32'h0BADF00D;
        end else if (if3.ram_we) begin
            mem3[if3.ram_addr] <= if3.ram_wdata;
        end
        p0 <= mem3[if3.ram_addr];
        p1 <= p0;
        p2 <= p1;
    end
    assign if3.ram_rdata = p2;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        port;   // 0 = CPU, 1 = DMA
        logic        we;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [8];

    // One transaction on the RAM_LAT=1 instance with full timing checks
    task automatic run_txn(input logic port, input logic we, input logic [8:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rdata);
        int exp_lat;
        int wecnt;
        bit got;
        exp_lat = we ? 2 : 3;
        wecnt   = 0;
        got     = 0;
        @(negedge clk);
        if (port) begin
            if1.d_req = 1'b1; if1.d_we = we; if1.d_addr = addr; if1.d_wdata = wdata;
        end else begin
            if1.c_req = 1'b1; if1.c_we = we; if1.c_addr = addr; if1.c_wdata = wdata;
        end
        for (int k = 1; k <= 12 && !got; k++) begin
            @(negedge clk);
            if (if1.ram_we) wecnt++;
            if (k == 1) begin
                chk("issue_addr",  32'(if1.ram_addr), 32'(addr));
                chk("issue_we",    32'(if1.ram_we),   32'(we));
                chk("issue_owner", 32'(if1.owner),    32'(port));
                chk("issue_busy",  32'(if1.busy),     32'd1);
                if (we) chk("issue_wdata", if1.ram_wdata, wdata);
            end
            if (k == 2) chk("ram_addr_idle", 32'(if1.ram_addr), 32'd0);
            if (if1.c_done || if1.d_done) begin
                got = 1;
                chk("done_latency", 32'(k), 32'(exp_lat));
                chk("done_cpu",     32'(if1.c_done), 32'(!port));
                chk("done_dma",     32'(if1.d_done), 32'(port));
                chk("done_rdata",   if1.rdata, exp_rdata);
                if1.c_req = 1'b0;
                if1.d_req = 1'b0;
            end
        end
        if (!got) chk("done_timeout", 32'd0, 32'd1);
        chk("we_cycles", 32'(wecnt), 32'(we));
        @(negedge clk);
        chk("post_busy", 32'(if1.busy), 32'd0);
        chk("post_done", 32'(if1.c_done | if1.d_done), 32'd0);
        chk("post_rdata", if1.rdata, 32'd0);
    endtask

    // Both requests rise together; both are reads
    task automatic contend(input logic exp_owner);
        bit got;
        got = 0;
        @(negedge clk);
        if1.c_req = 1'b1; if1.c_we = 1'b0; if1.c_addr = 9'h010;
        if1.d_req = 1'b1; if1.d_we = 1'b0; if1.d_addr = 9'h1FF;
        for (int k = 1; k <= 12 && !got; k++) begin
            @(negedge clk);
            if (if1.c_done || if1.d_done) begin
                got = 1;
                chk("cont_latency", 32'(k), 32'd3);
                chk("cont_owner",   32'(if1.owner), 32'(exp_owner));
                chk("cont_c_done",  32'(if1.c_done), 32'(!exp_owner));
                chk("cont_d_done",  32'(if1.d_done), 32'(exp_owner));
                chk("cont_rdata",   if1.rdata, exp_owner ? 32'hDEADBEEF : 32'h1234ABCD);
                if1.c_req = 1'b0;
                if1.d_req = 1'b0;
            end
        end
        if (!got) chk("cont_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        bit got;
        int dcount;
        if1.c_req = 0; if1.c_we = 0; if1.c_addr = '0; if1.c_wdata = '0;
        if1.d_req = 0; if1.d_we = 0; if1.d_addr = '0; if1.d_wdata = '0;
        if3.c_req = 0; if3.c_we = 0; if3.c_addr = '0; if3.c_wdata = '0;
        if3.d_req = 0; if3.d_we = 0; if3.d_addr = '0; if3.d_wdata = '0;

        vecs[0] = '{1'b0, 1'b0, 9'h010, 32'h0,        32'h1234ABCD};
        vecs[1] = '{1'b1, 1'b1, 9'h1FF, 32'hDEADBEEF, 32'h0};
        vecs[2] = '{1'b0, 1'b0, 9'h1FF, 32'h0,        32'hDEADBEEF};
        vecs[3] = '{1'b0, 1'b1, 9'h020, 32'h11112222, 32'h0};
        vecs[4] = '{1'b1, 1'b0, 9'h020, 32'h0,        32'h11112222};
        vecs[5] = '{1'b1, 1'b1, 9'h000, 32'hFFFFFFFF, 32'h0};
        vecs[6] = '{1'b1, 1'b0, 9'h000, 32'h0,        32'hFFFFFFFF};
        vecs[7] = '{1'b0, 1'b0, 9'h1FF, 32'h0,        32'hDEADBEEF};

        #2 Reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_c_done",    32'(if1.c_done),    32'd0);
        chk("rst_d_done",    32'(if1.d_done),    32'd0);
        chk("rst_rdata",     if1.rdata,          32'd0);
        chk("rst_busy",      32'(if1.busy),      32'd0);
        chk("rst_owner",     32'(if1.owner),     32'd0);
        chk("rst_ram_addr",  32'(if1.ram_addr),  32'd0);
        chk("rst_ram_wdata", if1.ram_wdata,      32'd0);
        chk("rst_ram_we",    32'(if1.ram_we),    32'd0);
        Reset = 1'b0;

        foreach (vecs[i]) begin
            run_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);
        end

        // Reset during the issue cycle of a write cuts the strobe at once
        @(negedge clk);
        if1.c_req = 1'b1; if1.c_we = 1'b1; if1.c_addr = 9'h030; if1.c_wdata = 32'h77777777;
        @(negedge clk);
        chk("wr_issue_we", 32'(if1.ram_we), 32'd1);
        Reset = 1'b1;
        #1;
        chk("rst_cut_we",   32'(if1.ram_we),   32'd0);
        chk("rst_cut_addr", 32'(if1.ram_addr), 32'd0);
        chk("rst_cut_busy", 32'(if1.busy),     32'd0);
        if1.c_req = 1'b0;
        @(negedge clk);
        Reset = 1'b0;

        // Contention straight out of reset
        contend(1'b0);
`ifdef MEMARB_RR_EN
        contend(1'b1);
`else
        contend(1'b0);
`endif

        // Reset during the wait cycle of a read
        @(negedge clk);
        if1.c_req = 1'b1; if1.c_we = 1'b0; if1.c_addr = 9'h1FF;
        @(negedge clk);
        @(negedge clk);
        chk("wait_busy", 32'(if1.busy), 32'd1);
        Reset = 1'b1;
        if1.c_req = 1'b0;
        #1;
        chk("wait_rst_busy",  32'(if1.busy),  32'd0);
        chk("wait_rst_rdata", if1.rdata,      32'd0);
        dcount = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            Reset = 1'b0;
            if (if1.c_done || if1.d_done) dcount++;
        end
        chk("wait_rst_no_done", 32'(dcount), 32'd0);
        run_txn(1'b0, 1'b0, 9'h1FF, 32'h0, 32'hDEADBEEF);

        // RAM_LAT = 3 read with the address changed mid-wait
        got = 0;
        @(negedge clk);
        if3.c_req = 1'b1; if3.c_we = 1'b0; if3.c_addr = 9'h044;
        for (int k = 1; k <= 15 && !got; k++) begin
            @(negedge clk);
            if (k == 1) chk("l3_issue_addr", 32'(if3.ram_addr), 32'h044);
            if (k == 2) begin
                chk("l3_wait_addr", 32'(if3.ram_addr), 32'd0);
                if3.c_addr = 9'h055;
            end
            if (k == 3) chk("l3_busy", 32'(if3.busy), 32'd1);
            if (if3.c_done || if3.d_done) begin
                got = 1;
                chk("l3_latency", 32'(k), 32'd5);
                chk("l3_rdata",   if3.rdata, 32'hA5A55A5A);
                chk("l3_d_done",  32'(if3.d_done), 32'd0);
                if3.c_req = 1'b0;
            end
        end
        if (!got) chk("l3_timeout", 32'd0, 32'd1);
        @(negedge clk);
        chk("l3_post_busy", 32'(if3.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
